// File: rtl/mbist_pkg.sv
// mbist_pkg
//   Shared definitions for the MBIST read-data checker:
//   - DATA_W / ADDR_W of the 512x56 macro
//   - the four background pattern words and the pat_sel encoding
//   - the checker state enum
//   - pat_word(): maps a pat_sel code to its background word
package mbist_pkg;

  localparam int DATA_W = 56;
  localparam int ADDR_W = 9;

  localparam logic [DATA_W-1:0] PAT_ALL0 = '0;
  localparam logic [DATA_W-1:0] PAT_ALL1 = '1;
  localparam logic [DATA_W-1:0] PAT_55   = {(DATA_W/2){2'b01}};
  localparam logic [DATA_W-1:0] PAT_AA   = {(DATA_W/2){2'b10}};

  typedef enum logic [1:0] {
    PAT_SEL_0  = 2'b00,
    PAT_SEL_1  = 2'b01,
    PAT_SEL_55 = 2'b10,
    PAT_SEL_AA = 2'b11
  } pat_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_e;

  function automatic logic [DATA_W-1:0] pat_word(input logic [1:0] sel);
    logic [DATA_W-1:0] w;
    w = PAT_ALL0;
    case (pat_sel_e'(sel))
      PAT_SEL_0:  w = PAT_ALL0;
      PAT_SEL_1:  w = PAT_ALL1;
      PAT_SEL_55: w = PAT_55;
      PAT_SEL_AA: w = PAT_AA;
      default:    w = PAT_ALL0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mbist_chk_align.sv
// mbist_chk_align
//   RD_LAT-deep shift pipe carrying {valid, address, expected word} of each
//   issued read so it lines up with the memory's data output.
//   Ports:
//     clk, rstn (sync, active-low)
//     flush_i         synchronous clear of every stage
//     vld_i/addr_i/exp_i   read entering the pipe this cycle
//     vld_o/addr_o/exp_o   read whose data is on mem_dout this cycle
module mbist_chk_align #(
  parameter int RD_LAT = 1,   // 1..4
  parameter int ADDR_W = 9,
  parameter int DATA_W = 56
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              vld_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] exp_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] exp_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] exp_q  [RD_LAT];

  // NOTE: the payload stages are cleared along with the valid bits so a reset
  // or flush leaves nothing stale in the pipe, not just nothing valid.
  always_ff @(posedge clk) begin
    if (!rstn || flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      exp_q[0]  <= exp_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign addr_o = addr_q[RD_LAT-1];
  assign exp_o  = exp_q[RD_LAT-1];

endmodule

// File: rtl/mbist_checker.sv
// mbist_checker
//   Compares memory read data against the expected background pattern for
//   every read the MBIST controller issues, counts mismatches (saturating),
//   captures the first failing address/data and reports pass/fail at the end.
//   Optional macro MBIST_CHK_DIAG_EN: enables the per-bit fail_bitmap_o
//   accumulator; without it fail_bitmap_o is constant 0.
//   Ports:
//     clk, rstn (sync, active-low)
//     chk_start_i   pulse: clear results, (re)enter RUN
//     rd_en_i, rd_addr_i, pat_sel_i   read issued this cycle + its background
//     mem_dout_i    memory data output (RD_LAT cycles after issue)
//     bist_done_i   controller issued its last operation
//     chk_busy_o, chk_done_o, chk_pass_o   status (registered)
//     err_cnt_o, first_fail_addr_o, first_fail_data_o, fail_bitmap_o   results
module mbist_checker #(
  parameter int DATA_W    = mbist_pkg::DATA_W,
  parameter int ADDR_W    = mbist_pkg::ADDR_W,
  parameter int RD_LAT    = 1,   // 1..4
  parameter int ERR_CNT_W = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 chk_start_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  input  logic [1:0]           pat_sel_i,
  input  logic [DATA_W-1:0]    mem_dout_i,
  input  logic                 bist_done_i,
  output logic                 chk_busy_o,
  output logic                 chk_done_o,
  output logic                 chk_pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [ADDR_W-1:0]    first_fail_addr_o,
  output logic [DATA_W-1:0]    first_fail_data_o,
  output logic [DATA_W-1:0]    fail_bitmap_o
);

  import mbist_pkg::*;

  localparam int DCNT_W = $clog2(RD_LAT + 1);

  chk_state_e            state_q, state_d;
  logic [DCNT_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  ff_flag_q, ff_flag_d;
  logic [ADDR_W-1:0]     ff_addr_q, ff_addr_d;
  logic [DATA_W-1:0]     ff_data_q, ff_data_d;
  logic                  busy_q, done_q, pass_q;

  logic                  al_flush, al_vld;
  logic [ADDR_W-1:0]     al_addr;
  logic [DATA_W-1:0]     al_exp;
  logic                  mismatch;

  // The pipe only runs while checking; a restart also discards reads in flight.
  assign al_flush = chk_start_i || (state_q == ST_IDLE) || (state_q == ST_DONE);

  mbist_chk_align #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_align (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (al_flush),
    .vld_i   ((state_q == ST_RUN) && rd_en_i),
    .addr_i  (rd_addr_i),
    .exp_i   (DATA_W'(pat_word(pat_sel_i))),
    .vld_o   (al_vld),
    .addr_o  (al_addr),
    .exp_o   (al_exp)
  );

  assign mismatch = al_vld && (mem_dout_i != al_exp);

  // NOTE: every variable gets its hold value before any branch so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    err_cnt_d   = err_cnt_q;
    ff_flag_d   = ff_flag_q;
    ff_addr_d   = ff_addr_q;
    ff_data_d   = ff_data_q;

    if (chk_start_i) begin
      // Restart wins over bist_done and over a compare landing this cycle.
      state_d     = ST_RUN;
      drain_cnt_d = '0;
      err_cnt_d   = '0;
      ff_flag_d   = 1'b0;
      ff_addr_d   = '0;
      ff_data_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bist_done_i) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DCNT_W'(RD_LAT);
          end
        end
        ST_DRAIN: begin
          // RD_LAT cycles lets the last read reach the compare, plus one to
          // register its result before DONE is reported.
          if (drain_cnt_q == '0) state_d = ST_DONE;
          else                   drain_cnt_d = drain_cnt_q - DCNT_W'(1);
        end
        default: ;
      endcase

      if (mismatch) begin
        if (err_cnt_q != {ERR_CNT_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        if (!ff_flag_q) begin
          ff_flag_d = 1'b1;
          ff_addr_d = al_addr;
          ff_data_d = mem_dout_i;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      err_cnt_q   <= '0;
      ff_flag_q   <= 1'b0;
      ff_addr_q   <= '0;
      ff_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      err_cnt_q   <= err_cnt_d;
      ff_flag_q   <= ff_flag_d;
      ff_addr_q   <= ff_addr_d;
      ff_data_q   <= ff_data_d;
      busy_q      <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q      <= (state_d == ST_DONE);
      pass_q      <= (state_d == ST_DONE) && (err_cnt_d == '0);
    end
  end

`ifdef MBIST_CHK_DIAG_EN
  logic [DATA_W-1:0] bitmap_q;

  always_ff @(posedge clk) begin
    if (!rstn || chk_start_i) bitmap_q <= '0;
    else if (mismatch)        bitmap_q <= bitmap_q | (mem_dout_i ^ al_exp);
  end

  assign fail_bitmap_o = bitmap_q;
`else
  assign fail_bitmap_o = '0;
`endif

  assign chk_busy_o        = busy_q;
  assign chk_done_o        = done_q;
  assign chk_pass_o        = pass_q;
  assign err_cnt_o         = err_cnt_q;
  assign first_fail_addr_o = ff_addr_q;
  assign first_fail_data_o = ff_data_q;

endmodule

// File: tb/tb_mbist_checker.sv
// tb_mbist_checker
//   Two checker instances share one stimulus stream:
//     A: RD_LAT=1, ERR_CNT_W=10    B: RD_LAT=3, ERR_CNT_W=4
//   Each has its own latency-matched memory model that returns the background
//   pattern XOR an injected fault mask. Expected end-of-run results are queued
//   when the final read is issued; a monitor per instance pops and compares on
//   each rising chk_done.
module tb_mbist_checker;

  localparam int DW    = 56;
  localparam int AW    = 9;
  localparam int EW_A  = 10;
  localparam int EW_B  = 4;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam logic [DW-1:0] JUNK = 56'hC3C3_C3C3_C3C3_C3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          chk_start = 1'b0;
  logic          rd_en = 1'b0;
  logic          bist_done = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [1:0]    pat_sel = '0;
  logic [DW-1:0] fault_mask = '0;

  logic [DW-1:0] dout_a, dout_b, memb_s0, memb_s1;

  logic            busy_a, done_a, pass_a;
  logic [EW_A-1:0] err_a;
  logic [AW-1:0]   ffa_a;
  logic [DW-1:0]   ffd_a, bmap_a;
  logic            busy_b, done_b, pass_b;
  logic [EW_B-1:0] err_b;
  logic [AW-1:0]   ffa_b;
  logic [DW-1:0]   ffd_b, bmap_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [DW-1:0] tb_pat(input logic [1:0] sel);
    case (sel)
      2'b00:   return 56'h00_0000_0000_0000;
      2'b01:   return 56'hFF_FFFF_FFFF_FFFF;
      2'b10:   return 56'h55_5555_5555_5555;
      default: return 56'hAA_AAAA_AAAA_AAAA;
    endcase
  endfunction

  mbist_checker #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT_A), .ERR_CNT_W(EW_A)) u_dut_a (
    .clk(clk), .rstn(rstn), .chk_start_i(chk_start), .rd_en_i(rd_en),
    .rd_addr_i(rd_addr), .pat_sel_i(pat_sel), .mem_dout_i(dout_a),
    .bist_done_i(bist_done), .chk_busy_o(busy_a), .chk_done_o(done_a),
    .chk_pass_o(pass_a), .err_cnt_o(err_a), .first_fail_addr_o(ffa_a),
    .first_fail_data_o(ffd_a), .fail_bitmap_o(bmap_a)
  );

  mbist_checker #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT_B), .ERR_CNT_W(EW_B)) u_dut_b (
    .clk(clk), .rstn(rstn), .chk_start_i(chk_start), .rd_en_i(rd_en),
    .rd_addr_i(rd_addr), .pat_sel_i(pat_sel), .mem_dout_i(dout_b),
    .bist_done_i(bist_done), .chk_busy_o(busy_b), .chk_done_o(done_b),
    .chk_pass_o(pass_b), .err_cnt_o(err_b), .first_fail_addr_o(ffa_b),
    .first_fail_data_o(ffd_b), .fail_bitmap_o(bmap_b)
  );

  // Memory models: data for a read issued at edge t is on dout at edge t+LAT.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    dout_a  <= rd_en ? (tb_pat(pat_sel) ^ fault_mask) : JUNK;
    memb_s0 <= rd_en ? (tb_pat(pat_sel) ^ fault_mask) : JUNK;
    memb_s1 <= memb_s0;
    dout_b  <= memb_s1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] err;
    logic [63:0] pass;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] bmap;
    int          done_cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // k = edge at which bist_done is sampled
  task automatic push_exp(input int raw_err, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW-1:0] bmap, input int k);
    exp_t e;
    e.pass = 64'(raw_err == 0);
    e.addr = 64'(addr);
    e.data = 64'(data);
`ifdef MBIST_CHK_DIAG_EN
    e.bmap = 64'(bmap);
`else
    e.bmap = 64'd0;
`endif
    e.err      = 64'((raw_err > 1023) ? 1023 : raw_err);
    e.done_cyc = k + LAT_A + 1;
    q_a.push_back(e);
    e.err      = 64'((raw_err > 15) ? 15 : raw_err);
    e.done_cyc = k + LAT_B + 1;
    q_b.push_back(e);
  endtask

  task automatic cmp_done(input string tag, input exp_t e, input logic [63:0] err,
                          input logic pass, input logic busy, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW-1:0] bmap);
    check({tag, " done cycle"}, 64'(cyc), 64'(e.done_cyc));
    check({tag, " err_cnt"}, err, e.err);
    check({tag, " chk_pass"}, 64'(pass), e.pass);
    check({tag, " chk_busy"}, 64'(busy), 64'd0);
    check({tag, " first_fail_addr"}, 64'(addr), e.addr);
    check({tag, " first_fail_data"}, 64'(data), e.data);
    check({tag, " fail_bitmap"}, 64'(bmap), e.bmap);
  endtask

  logic done_a_prev = 1'b0;
  logic done_b_prev = 1'b0;
  exp_t e_a, e_b;

  always @(negedge clk) begin
    if (done_a && !done_a_prev) begin
      check("A expectation queued at done", 64'(q_a.size() != 0), 64'd1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        cmp_done("A", e_a, 64'(err_a), pass_a, busy_a, ffa_a, ffd_a, bmap_a);
      end
    end
    done_a_prev <= done_a;
  end

  always @(negedge clk) begin
    if (done_b && !done_b_prev) begin
      check("B expectation queued at done", 64'(q_b.size() != 0), 64'd1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        cmp_done("B", e_b, 64'(err_b), pass_b, busy_b, ffa_b, ffd_b, bmap_b);
      end
    end
    done_b_prev <= done_b;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_chk();
    chk_start = 1'b1;
    rd_en     = 1'b0;
    bist_done = 1'b0;
    tick();
    chk_start = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] p,
                         input logic [DW-1:0] m, input logic last);
    rd_en      = 1'b1;
    rd_addr    = a;
    pat_sel    = p;
    fault_mask = m;
    bist_done  = last;
    tick();
    rd_en      = 1'b0;
    bist_done  = 1'b0;
    fault_mask = '0;
  endtask

  // Bounded wait for both instances to finish; undelivered expectations fail.
  task automatic wait_done(input string tag);
    repeat (8) tick();
    check({tag, " A scoreboard drained"}, 64'(q_a.size()), 64'd0);
    check({tag, " B scoreboard drained"}, 64'(q_b.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " A busy"}, 64'(busy_a), 64'd0);
    check({tag, " A done"}, 64'(done_a), 64'd0);
    check({tag, " A pass"}, 64'(pass_a), 64'd0);
    check({tag, " A err_cnt"}, 64'(err_a), 64'd0);
    check({tag, " A ff_addr"}, 64'(ffa_a), 64'd0);
    check({tag, " A ff_data"}, 64'(ffd_a), 64'd0);
    check({tag, " A bitmap"}, 64'(bmap_a), 64'd0);
    check({tag, " B busy"}, 64'(busy_b), 64'd0);
    check({tag, " B done"}, 64'(done_b), 64'd0);
    check({tag, " B pass"}, 64'(pass_b), 64'd0);
    check({tag, " B err_cnt"}, 64'(err_b), 64'd0);
    check({tag, " B ff_addr"}, 64'(ffa_b), 64'd0);
    check({tag, " B ff_data"}, 64'(ffd_b), 64'd0);
    check({tag, " B bitmap"}, 64'(bmap_b), 64'd0);
  endtask

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    check_zero("reset");

    // Clean run: all 512 addresses, all four patterns
    start_chk();
    for (int p = 0; p < 4; p++) begin
      for (int a = 0; a < 512; a++) begin
        if (p == 3 && a == 511) push_exp(0, '0, '0, '0, cyc + 1);
        do_read(AW'(a), 2'(p), '0, (p == 3 && a == 511));
      end
    end
    wait_done("clean");

    // Single fault: bit 7 of addr 0x1A3 under 0x55.. background
    start_chk();
    for (int a = 'h1A0; a <= 'h1A7; a++) begin
      if (a == 'h1A7) push_exp(1, 9'h1A3, 56'h55_5555_5555_55D5, 56'h80, cyc + 1);
      do_read(AW'(a), 2'b10, (a == 'h1A3) ? 56'h80 : 56'h0, (a == 'h1A7));
    end
    wait_done("single");

    // Saturation: 20 faulty reads, one bit each cycling over bits 0..7
    start_chk();
    for (int i = 0; i < 20; i++) begin
      if (i == 19) push_exp(20, 9'h010, 56'h1, 56'hFF, cyc + 1);
      do_read(AW'('h10 + i), 2'b00, DW'(1) << (i % 8), (i == 19));
    end
    wait_done("saturate");

    // Latency: fault on the read issued with bist_done
    start_chk();
    for (int a = 0; a < 6; a++) begin
      if (a == 5) push_exp(1, 9'h005, 56'h2A_AAAA_AAAA_AAAA, 56'h80_0000_0000_0000, cyc + 1);
      do_read(AW'(a), 2'b11, (a == 5) ? 56'h80_0000_0000_0000 : 56'h0, (a == 5));
    end
    wait_done("latency");

    // Restart mid-RUN after 2 errors; a faulty read in flight is discarded
    start_chk();
    do_read(9'h100, 2'b01, 56'h1, 1'b0);
    do_read(9'h101, 2'b01, 56'h2, 1'b0);
    for (int a = 'h102; a <= 'h105; a++) do_read(AW'(a), 2'b01, '0, 1'b0);
    check("restart A err before", 64'(err_a), 64'd2);
    check("restart B err before", 64'(err_b), 64'd2);
    check("restart A ff_addr before", 64'(ffa_a), 64'h100);
    check("restart B ff_data before", 64'(ffd_b), 64'hFF_FFFF_FFFF_FFFE);
    do_read(9'h106, 2'b01, 56'h4, 1'b0);
    start_chk();
    check("restart A err", 64'(err_a), 64'd0);
    check("restart B err", 64'(err_b), 64'd0);
    check("restart A ff_addr", 64'(ffa_a), 64'd0);
    check("restart B ff_data", 64'(ffd_b), 64'd0);
    check("restart A busy", 64'(busy_a), 64'd1);
    check("restart B done", 64'(done_b), 64'd0);
    for (int a = 0; a < 8; a++) begin
      if (a == 7) push_exp(0, '0, '0, '0, cyc + 1);
      do_read(AW'(a), 2'b01, '0, (a == 7));
    end
    wait_done("restart");

    // Reset mid-DRAIN, then IDLE ignores reads and bist_done
    start_chk();
    do_read(9'h000, 2'b00, '0, 1'b0);
    do_read(9'h001, 2'b00, 56'h1, 1'b0);
    do_read(9'h002, 2'b00, '0, 1'b1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_zero("reset in drain");
    do_read(9'h030, 2'b00, 56'h1, 1'b0);
    do_read(9'h031, 2'b00, 56'h1, 1'b0);
    do_read(9'h032, 2'b00, 56'h1, 1'b1);
    repeat (6) tick();
    check_zero("idle ignores reads");

    // Recovery after reset
    start_chk();
    for (int a = 0; a < 4; a++) begin
      if (a == 3) push_exp(0, '0, '0, '0, cyc + 1);
      do_read(AW'(a), 2'b10, '0, (a == 3));
    end
    wait_done("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
